nand4_if: RTL and testbench

NAND4_IF -- requirements
Module: nand4_if

---
 rtl/nand4_pkg.sv | 16 +
 rtl/nand_reduce.sv | 12 +
 rtl/nand4_if.sv | 53 +++++
 tb/tb_nand4_if.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/nand4_pkg.sv
// Shared constants and helpers for the registered NAND block.
package nand4_pkg;

  // Default operand width and zero-event counter width.
  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Largest value representable in a w-bit counter (2^w - 1), computed in
  // 33 bits so that w = 32 does not overflow before the subtraction.
  function automatic logic [31:0] sat_max(input int w);
    logic [32:0] top_bit;
    top_bit = 33'd1 << w;
    return 32'(top_bit - 33'd1);
  endfunction

endpackage

// File: rtl/nand_reduce.sv
// Combinational reduction NAND of a WIDTH-bit operand.
module nand_reduce #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  output logic             out
);

  // Reduction NAND keeps standard X/Z propagation: unknown bits are not masked.
  assign out = ~&in;

endmodule

// File: rtl/nand4_if.sv
// NAND of a WIDTH-bit operand with a registered copy, a change pulse and a
// saturating count of cycles in which the NAND output is low.
module nand4_if
  import nand4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic             y,
  output logic             y_q,
  output logic             chg,
  output logic [CNT_W-1:0] zero_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic             y_q_reg;
  logic             chg_reg;
  logic [CNT_W-1:0] zero_cnt_reg;

  // The combinational path never sees clk or rst.
  nand_reduce #(
    .WIDTH(WIDTH)
  ) u_nand_reduce (
    .in (a),
    .out(y)
  );

  // All state: registered y, change pulse (new y differs from held y),
  // and the zero counter, which holds once it reaches its maximum.
  // Reset takes priority over an increment at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_reg      <= 1'b1;
      chg_reg      <= 1'b0;
      zero_cnt_reg <= '0;
    end else begin
      y_q_reg <= y;
      chg_reg <= y ^ y_q_reg;
      if (!y && (zero_cnt_reg != CNT_MAX)) begin
        zero_cnt_reg <= zero_cnt_reg + 1'b1;
      end
    end
  end

  assign y_q      = y_q_reg;
  assign chg      = chg_reg;
  assign zero_cnt = zero_cnt_reg;

endmodule

// File: tb/tb_nand4_if.sv
// Directed bench for nand4_if: vector table for sweep/toggle, hand sequences
// for saturation, reset corner cases and an 8-bit width sweep.
module tb_nand4_if;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [7:0] a8;

  logic       y, y_q, chg;
  logic [7:0] zero_cnt;
  logic       y4, y_q4, chg4;
  logic [3:0] zero_cnt4;
  logic       y8, y_q8, chg8;
  logic [7:0] zero_cnt8;

  int checks = 0;
  int errors = 0;

  nand4_if dut (
    .clk(clk), .rst(rst), .a(a),
    .y(y), .y_q(y_q), .chg(chg), .zero_cnt(zero_cnt)
  );

  nand4_if #(.WIDTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .a(a),
    .y(y4), .y_q(y_q4), .chg(chg4), .zero_cnt(zero_cnt4)
  );

  nand4_if #(.WIDTH(8), .CNT_W(8)) dut_w8 (
    .clk(clk), .rst(rst), .a(a8),
    .y(y8), .y_q(y_q8), .chg(chg8), .zero_cnt(zero_cnt8)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic       exp_y;
    logic       exp_yq;
    logic       exp_chg;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [3:0] va, input logic vy, input logic vyq,
                         input logic vchg, input int vcnt);
    vec_t v;
    v.a = va; v.exp_y = vy; v.exp_yq = vyq; v.exp_chg = vchg; v.exp_cnt = vcnt;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    a   = 4'h0;
    a8  = 8'h00;

    // Sweep 0..14: y stays 1, y_q stays at its reset value, no pulses.
    for (int i = 0; i < 15; i++) add_vec(4'(i), 1'b1, 1'b1, 1'b0, 0);
    add_vec(4'hF, 1'b0, 1'b0, 1'b1, 1);   // first all-ones value
    add_vec(4'hE, 1'b1, 1'b1, 1'b1, 1);   // back to 1: change pulse
    add_vec(4'hE, 1'b1, 1'b1, 1'b0, 1);   // steady
    add_vec(4'hF, 1'b0, 1'b0, 1'b1, 2);   // toggle 1 -> 0
    add_vec(4'hE, 1'b1, 1'b1, 1'b1, 2);   // toggle 0 -> 1
    add_vec(4'hE, 1'b1, 1'b1, 1'b0, 2);   // pulse ends

    // Reset state.
    tick();
    tick();
    check("reset_y_q", int'(y_q), 1);
    check("reset_chg", int'(chg), 0);
    check("reset_cnt", int'(zero_cnt), 0);
    rst = 1'b0;

    // Table: drive a, check y combinationally, then check registered outputs.
    foreach (vecs[i]) begin
      a = vecs[i].a;
      #1;
      check($sformatf("vec%0d_y", i), int'(y), int'(vecs[i].exp_y));
      tick();
      check($sformatf("vec%0d_y_q", i), int'(y_q), int'(vecs[i].exp_yq));
      check($sformatf("vec%0d_chg", i), int'(chg), int'(vecs[i].exp_chg));
      check($sformatf("vec%0d_cnt", i), int'(zero_cnt), vecs[i].exp_cnt);
      $display("vec %0d: a=%h y=%b y_q=%b chg=%b cnt=%0d", i, a, y, y_q, chg, zero_cnt);
    end

    // Saturation with a 4-bit counter: 20 cycles of a = F.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a = 4'hF;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), int'(zero_cnt4), (i < 15) ? i : 15);
      check($sformatf("sat_y_q_%0d", i), int'(y_q4), 0);
      $display("sat cycle %0d: cnt4=%0d y_q4=%b", i, zero_cnt4, y_q4);
    end

    // Reset while saturated clears the counter; rst does not touch y.
    rst = 1'b1;
    #1;
    check("rst_y_comb", int'(y), 0);
    tick();
    check("sat_rst_cnt", int'(zero_cnt4), 0);
    check("sat_rst_y_q", int'(y_q4), 1);
    $display("sat reset: cnt4=%0d y_q4=%b", zero_cnt4, y_q4);

    // Reset mid-count at 7, with y = 0 at the reset edge (reset wins).
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_cnt7", int'(zero_cnt), 7);
    rst = 1'b1;
    tick();
    check("mid_rst_cnt", int'(zero_cnt), 0);
    check("mid_rst_y_q", int'(y_q), 1);
    check("mid_rst_chg", int'(chg), 0);
    rst = 1'b0;
    tick();
    check("mid_resume_cnt", int'(zero_cnt), 1);
    check("mid_resume_y_q", int'(y_q), 0);
    check("mid_resume_chg", int'(chg), 1);
    $display("mid reset resume: cnt=%0d y_q=%b chg=%b", zero_cnt, y_q, chg);

    // Post-reset with a = 0 from a y_q = 0 state: no spurious pulse.
    rst = 1'b1;
    a = 4'h0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("post_chg_%0d", i), int'(chg), 0);
      check($sformatf("post_y_q_%0d", i), int'(y_q), 1);
      check($sformatf("post_cnt_%0d", i), int'(zero_cnt), 0);
    end
    $display("post reset a=0: chg=%b y_q=%b cnt=%0d", chg, y_q, zero_cnt);

    // Width 8: y low only for all ones.
    for (int v = 0; v < 256; v++) begin
      a8 = 8'(v);
      #1;
      check($sformatf("w8_y_%02h", v), int'(y8), (v == 255) ? 0 : 1);
    end
    tick();
    check("w8_y_q_ff", int'(y_q8), 0);
    $display("width8 sweep done: y_q8=%b", y_q8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
